// File: rtl/game_ctrl.sv
// ============================================================================
// game_ctrl : game sequencer, tick pacing, collision/catch arbitration,
//             BCD scoring and lives for the block-catching game.
// Revision  : 1.0
// ============================================================================
`default_nettype none

module game_ctrl #(
    parameter int TICK_DIV      = 833333,
    parameter int PADDLE_W      = 80,
    parameter int PADDLE_Y      = 440,
    parameter int SQ_SIZE       = 20,
    parameter int LIVES         = 3,
    parameter int RESPAWN_TICKS = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_flag,
    input  logic       pause_flag,
    input  logic [9:0] x,
    input  logic [9:0] x2,
    input  logic [9:0] vga_x,
    input  logic [9:0] vga_y,
    output logic       move_en,
    output logic       square_reset,
    output logic [2:0] state,
    output logic [7:0] score1,
    output logic [7:0] score2,
    output logic [1:0] lives,
    output logic       game_over
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int RW = $clog2(RESPAWN_TICKS + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PLAY    = 3'd1,
        S_PAUSE   = 3'd2,
        S_RESPAWN = 3'd3,
        S_OVER    = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [RW-1:0] resp_cnt_q, resp_cnt_d;
    logic [7:0]    score1_q, score1_d;
    logic [7:0]    score2_q, score2_d;
    logic [1:0]    lives_q, lives_d;
    logic          move_en_q, move_en_d;
    logic          sq_reset_q, sq_reset_d;
    logic          game_over_q, game_over_d;

    logic          tick;
    logic [10:0]   sq_right, sq_bottom;
    logic          landing, overlap1, overlap2;

    // Saturating two-digit BCD increment.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h99)
            r = v;
        else if (v[3:0] >= 4'd9)
            r = {v[7:4] + 4'd1, 4'd0};
        else
            r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    assign tick       = (tick_cnt_q == TW'(TICK_DIV - 1));
    assign tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);

    // Widened to 11 bits so edge sums near 1023 cannot wrap.
    assign sq_right  = {1'b0, vga_x} + 11'(SQ_SIZE);
    assign sq_bottom = {1'b0, vga_y} + 11'(SQ_SIZE);
    assign landing   = (sq_bottom >= 11'(PADDLE_Y));
    assign overlap1  = (sq_right > {1'b0, x})  && ({1'b0, vga_x} < ({1'b0, x}  + 11'(PADDLE_W)));
    assign overlap2  = (sq_right > {1'b0, x2}) && ({1'b0, vga_x} < ({1'b0, x2} + 11'(PADDLE_W)));

    always_comb begin
        state_d    = state_q;
        resp_cnt_d = resp_cnt_q;
        score1_d   = score1_q;
        score2_d   = score2_q;
        lives_d    = lives_q;
        move_en_d  = 1'b0;
        sq_reset_d = 1'b0;

        case (state_q)
            S_IDLE, S_OVER: begin
                if (start_flag) begin
                    score1_d   = 8'h00;
                    score2_d   = 8'h00;
                    lives_d    = 2'(LIVES);
                    sq_reset_d = 1'b1;
                    state_d    = S_PLAY;
                end
            end
            S_PLAY: begin
                if (pause_flag) begin
                    state_d = S_PAUSE;
                end else if (tick) begin
                    if (landing && overlap1) begin
                        score1_d   = bcd_inc(score1_q);
                        sq_reset_d = 1'b1;
                        resp_cnt_d = '0;
                        state_d    = S_RESPAWN;
                    end else if (landing && overlap2) begin
                        score2_d   = bcd_inc(score2_q);
                        sq_reset_d = 1'b1;
                        resp_cnt_d = '0;
                        state_d    = S_RESPAWN;
                    end else if (landing) begin
                        if (lives_q <= 2'd1) begin
                            lives_d = 2'd0;
                            state_d = S_OVER;
                        end else begin
                            lives_d    = lives_q - 2'd1;
                            sq_reset_d = 1'b1;
                            resp_cnt_d = '0;
                            state_d    = S_RESPAWN;
                        end
                    end else begin
                        move_en_d = 1'b1;
                    end
                end
            end
            S_PAUSE: begin
                if (pause_flag)
                    state_d = S_PLAY;
            end
            S_RESPAWN: begin
                if (tick) begin
                    resp_cnt_d = resp_cnt_q + RW'(1);
                    if (resp_cnt_d == RW'(RESPAWN_TICKS))
                        state_d = S_PLAY;
                end
            end
            default: state_d = S_IDLE;
        endcase

        game_over_d = (state_d == S_OVER);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            tick_cnt_q  <= '0;
            resp_cnt_q  <= '0;
            score1_q    <= 8'h00;
            score2_q    <= 8'h00;
            lives_q     <= 2'(LIVES);
            move_en_q   <= 1'b0;
            sq_reset_q  <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            resp_cnt_q  <= resp_cnt_d;
            score1_q    <= score1_d;
            score2_q    <= score2_d;
            lives_q     <= lives_d;
            move_en_q   <= move_en_d;
            sq_reset_q  <= sq_reset_d;
            game_over_q <= game_over_d;
        end
    end

    assign state        = state_q;
    assign score1       = score1_q;
    assign score2       = score2_q;
    assign lives        = lives_q;
    assign move_en      = move_en_q;
    assign square_reset = sq_reset_q;
    assign game_over    = game_over_q;

endmodule

`default_nettype wire

// File: tb/tb_game_ctrl.sv
// ============================================================================
// tb_game_ctrl : scoreboard bench for game_ctrl against a rule-level model.
// Revision     : 1.0
// ============================================================================
`default_nettype none

module tb_game_ctrl;

    localparam int TD = 4;
    localparam int RT = 2;
    localparam int LV = 3;
    localparam int PW = 80;
    localparam int SQ = 20;
    localparam int PY = 440;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_flag = 1'b0;
    logic       pause_flag = 1'b0;
    logic [9:0] x = '0, x2 = '0, vga_x = '0, vga_y = '0;
    logic       move_en, square_reset, game_over;
    logic [2:0] state;
    logic [7:0] score1, score2;
    logic [1:0] lives;

    game_ctrl #(
        .TICK_DIV(TD), .PADDLE_W(PW), .PADDLE_Y(PY),
        .SQ_SIZE(SQ), .LIVES(LV), .RESPAWN_TICKS(RT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .start_flag(start_flag), .pause_flag(pause_flag),
        .x(x), .x2(x2), .vga_x(vga_x), .vga_y(vga_y),
        .move_en(move_en), .square_reset(square_reset),
        .state(state), .score1(score1), .score2(score2),
        .lives(lives), .game_over(game_over)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       me;
        logic       sr;
        logic [2:0] st;
        logic [7:0] s1;
        logic [7:0] s2;
        logic [1:0] lv;
        logic       go;
    } obs_t;

    obs_t exp_q[$];
    obs_t mon_e, mon_a;
    int   errs = 0;
    int   checks = 0;

    // Model state: scores held as plain decimal integers.
    int m_st, m_s1, m_s2, m_lv, m_tc, m_rc;

    function automatic logic [7:0] to_bcd(input int s);
        return 8'(((s / 10) << 4) | (s % 10));
    endfunction

    function automatic obs_t cur_obs();
        obs_t o;
        o = '{me: move_en, sr: square_reset, st: state, s1: score1,
              s2: score2, lv: lives, go: game_over};
        return o;
    endfunction

    task automatic model_reset();
        m_st = 0; m_s1 = 0; m_s2 = 0; m_lv = LV; m_tc = 0; m_rc = 0;
    endtask

    function automatic bit covers(input int p, input int vx);
        return (vx + SQ > p) && (vx < p + PW);
    endfunction

    // Apply one cycle's inputs and queue the outputs expected after the edge.
    task automatic drive(input bit st, input bit ps, input int px, input int px2,
                         input int pvx, input int pvy);
        obs_t e;
        bit   tk, me, sr;
        start_flag = st; pause_flag = ps;
        x = 10'(px); x2 = 10'(px2); vga_x = 10'(pvx); vga_y = 10'(pvy);
        tk = (m_tc == TD - 1);
        me = 0; sr = 0;
        if (m_st == 0 || m_st == 4) begin
            if (st) begin
                m_s1 = 0; m_s2 = 0; m_lv = LV; sr = 1; m_st = 1;
            end
        end else if (m_st == 1) begin
            if (ps) m_st = 2;
            else if (tk) begin
                if (pvy + SQ >= PY) begin
                    if (covers(px, pvx)) begin
                        m_s1 = (m_s1 < 99) ? m_s1 + 1 : 99; sr = 1; m_st = 3; m_rc = 0;
                    end else if (covers(px2, pvx)) begin
                        m_s2 = (m_s2 < 99) ? m_s2 + 1 : 99; sr = 1; m_st = 3; m_rc = 0;
                    end else begin
                        m_lv = (m_lv > 0) ? m_lv - 1 : 0;
                        if (m_lv == 0) m_st = 4;
                        else begin sr = 1; m_st = 3; m_rc = 0; end
                    end
                end else me = 1;
            end
        end else if (m_st == 2) begin
            if (ps) m_st = 1;
        end else if (m_st == 3) begin
            if (tk) begin
                m_rc++;
                if (m_rc >= RT) m_st = 1;
            end
        end
        m_tc = (m_tc + 1) % TD;
        e = '{me: me, sr: sr, st: 3'(m_st), s1: to_bcd(m_s1), s2: to_bcd(m_s2),
              lv: 2'(m_lv), go: (m_st == 4)};
        exp_q.push_back(e);
    endtask

    task automatic step(input bit st, input bit ps, input int px, input int px2,
                        input int pvx, input int pvy);
        @(negedge clk);
        drive(st, ps, px, px2, pvx, pvy);
    endtask

    task automatic run(input int n, input int px, input int px2,
                       input int pvx, input int pvy);
        for (int i = 0; i < n; i++) step(0, 0, px, px2, pvx, pvy);
    endtask

    task automatic check_reset(input string name);
        obs_t a, r;
        a = cur_obs();
        r = '{me: 0, sr: 0, st: 3'd0, s1: 8'h00, s2: 8'h00, lv: 2'(LV), go: 0};
        checks++;
        if (a !== r) begin
            errs++;
            $display("FAIL %s: got %h required %h", name, a, r);
        end
    endtask

    // Monitor: every registered DUT output set is compared against the queue.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_a = cur_obs();
            checks++;
            if (mon_a !== mon_e) begin
                errs++;
                $display("FAIL outputs t=%0t: got me=%b sr=%b st=%0d s1=%h s2=%h lv=%0d go=%b, required me=%b sr=%b st=%0d s1=%h s2=%h lv=%0d go=%b",
                         $time, mon_a.me, mon_a.sr, mon_a.st, mon_a.s1, mon_a.s2, mon_a.lv, mon_a.go,
                         mon_e.me, mon_e.sr, mon_e.st, mon_e.s1, mon_e.s2, mon_e.lv, mon_e.go);
            end
        end
    end

    task automatic run_until_state(input int target, input int limit, input string name,
                                   input int px, input int px2, input int pvx, input int pvy);
        int n;
        n = 0;
        while (m_st != target && n < limit) begin
            step((m_st == 0 || m_st == 4), (m_st == 2), px, px2, pvx, pvy);
            n++;
        end
        checks++;
        if (m_st != target) begin
            errs++;
            $display("FAIL %s: model state %0d required %0d within %0d cycles", name, m_st, target, limit);
        end
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #2 check_reset("initial_reset");
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        run(19, 100, 300, 150, 420);

        // Start, then free motion with the square high on screen.
        step(1, 0, 0, 0, 0, 0);
        run(12, 0, 300, 150, 0);

        // Player 1 catch, respawn, back to play.
        run(16, 100, 300, 150, 420);
        run(8, 100, 300, 150, 0);

        // Both paddles overlap: player 1 must win.
        run(14, 100, 120, 150, 430);
        run(8, 100, 120, 150, 0);

        // Three misses to game over, then restart.
        run_until_state(4, 200, "miss_to_over", 0, 200, 500, 440);
        run(6, 0, 200, 500, 440);
        step(1, 0, 0, 0, 0, 0);
        run(5, 0, 300, 150, 0);

        // Player 2 catches until its score saturates at 99.
        while (m_s2 < 99 && m_st != 4) step(0, 0, 0, 300, 320, 430);
        run(40, 0, 300, 320, 430);

        // Pause on a tick cycle, hold, then resume.
        run_until_state(1, 50, "back_to_play", 0, 300, 150, 0);
        while (m_tc != TD - 1) step(0, 0, 0, 300, 150, 0);
        step(0, 1, 0, 300, 150, 430);
        run(9, 0, 300, 150, 430);
        step(0, 1, 0, 300, 150, 0);
        run(8, 0, 300, 150, 0);

        // Randomised play with sporadic start/pause pulses.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 50) == 0, ($urandom % 40) == 0,
                 $urandom_range(0, 560), $urandom_range(0, 560),
                 $urandom_range(0, 639), $urandom_range(380, 460));
        end

        // Asynchronous reset in the middle of RESPAWN.
        run_until_state(3, 400, "reach_respawn", 100, 300, 150, 430);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_reset("async_reset_respawn");
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        run(6, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        run(10, 0, 300, 150, 0);

        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errs++;
            $display("FAIL queue_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

`default_nettype wire
